// File: rtl/serial_to_parallel.sv
// Serial command frame receiver that issues single-beat parallel bus requests.
// Optional S2P_PARITY_CHECK_EN drops command frames whose parity bit is wrong.

package bus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_READ        = 2'b00,
        CMD_WRITE       = 2'b01,
        CMD_SPLIT_START = 2'b10,
        CMD_RSVD        = 2'b11
    } cmd_e;

endpackage

module serial_to_parallel #(
    parameter int ADDR_WIDTH  = bus_pkg::ADDR_W,
    parameter int DATA_WIDTH  = bus_pkg::DATA_W,
    parameter int FRAME_WIDTH = 27
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sdata_i,
    input  logic                  sclk_i,
    input  logic                  svalid_i,
    output logic                  sready_o,
    output logic                  sdata_o,
    output logic                  sclk_resp_o,
    output logic                  svalid_resp_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i
);

    localparam int STOP   = 0;
    localparam int PAR    = 1;
    localparam int DLSB   = 2;
    localparam int DMSB   = DLSB + DATA_WIDTH - 1;
    localparam int ALSB   = DMSB + 1;
    localparam int AMSB   = ALSB + ADDR_WIDTH - 1;
    localparam int CLSB   = AMSB + 1;
    localparam int CMSB   = CLSB + 1;
    localparam int START  = CMSB + 1;
    localparam int CW     = $clog2(FRAME_WIDTH + 1);
    localparam int RESP_W = DATA_WIDTH + 4;
    localparam int TW     = $clog2(RESP_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_CHECK,
        S_REQ,
        S_TX
    } state_e;

    state_e state;

    logic [1:0] sclk_sync;
    logic [1:0] sdata_sync;
    logic [1:0] svalid_sync;
    logic       sclk_d;
    logic       strobe;
    logic       sdata_s;
    logic       svalid_s;

    logic [FRAME_WIDTH-1:0] shreg;
    logic [CW-1:0]          rx_cnt;
    logic [RESP_W-1:0]      resp_sr;
    logic [TW-1:0]          tx_cnt;
    logic [1:0]             phase;

    bus_pkg::cmd_e          cmd;
    logic                   par_ok;
    logic                   frame_ok;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic [RESP_W-1:0]      resp_word;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync   <= '0;
            sdata_sync  <= '0;
            svalid_sync <= '0;
            sclk_d      <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[0], sclk_i};
            sdata_sync  <= {sdata_sync[0], sdata_i};
            svalid_sync <= {svalid_sync[0], svalid_i};
            sclk_d      <= sclk_sync[1];
        end
    end

    assign sdata_s  = sdata_sync[1];
    assign svalid_s = svalid_sync[1];
    assign strobe   = sclk_sync[1] & ~sclk_d;

    assign cmd = bus_pkg::cmd_e'(shreg[CMSB:CLSB]);

`ifdef S2P_PARITY_CHECK_EN
    assign par_ok = (^shreg[CMSB:DLSB]) == shreg[PAR];
`else
    logic unused_par;
    assign unused_par = shreg[PAR];
    assign par_ok     = 1'b1;
`endif

    assign frame_ok = shreg[START] & shreg[STOP]
                    & (cmd != bus_pkg::CMD_RSVD) & par_ok;

    // Writes never echo data back, whatever the slave drives on rdata_i.
    assign rsp_data  = we_o ? '0 : rdata_i;
    assign resp_word = {1'b1, err_i, rsp_data, ^{err_i, rsp_data}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            shreg         <= '0;
            rx_cnt        <= '0;
            resp_sr       <= '0;
            tx_cnt        <= '0;
            phase         <= '0;
            sready_o      <= 1'b0;
            sdata_o       <= 1'b0;
            sclk_resp_o   <= 1'b0;
            svalid_resp_o <= 1'b0;
            valid_o       <= 1'b0;
            addr_o        <= '0;
            wdata_o       <= '0;
            we_o          <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    sready_o <= 1'b1;
                    if (strobe && svalid_s && sdata_s) begin
                        shreg    <= {{(FRAME_WIDTH-1){1'b0}}, 1'b1};
                        rx_cnt   <= CW'(1);
                        state    <= S_RX;
                        sready_o <= 1'b0;
                    end
                end
                S_RX: begin
                    if (!svalid_s) begin
                        state    <= S_IDLE;
                        sready_o <= 1'b1;
                    end else if (strobe) begin
                        shreg  <= {shreg[FRAME_WIDTH-2:0], sdata_s};
                        rx_cnt <= rx_cnt + CW'(1);
                        if (rx_cnt == CW'(FRAME_WIDTH - 1))
                            state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        state   <= S_REQ;
                        valid_o <= 1'b1;
                        addr_o  <= shreg[AMSB:ALSB];
                        we_o    <= (cmd != bus_pkg::CMD_READ);
                        wdata_o <= (cmd == bus_pkg::CMD_READ)
                                   ? '0 : shreg[DMSB:DLSB];
                    end else begin
                        state    <= S_IDLE;
                        sready_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ready_i) begin
                        state         <= S_TX;
                        valid_o       <= 1'b0;
                        resp_sr       <= resp_word;
                        sdata_o       <= resp_word[RESP_W-1];
                        svalid_resp_o <= 1'b1;
                        sclk_resp_o   <= 1'b0;
                        phase         <= '0;
                        tx_cnt        <= '0;
                    end
                end
                S_TX: begin
                    // Four clk_i per bit: phases 0-1 low, 2-3 high.
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        sclk_resp_o <= 1'b0;
                        if (tx_cnt == TW'(RESP_W - 1)) begin
                            state         <= S_IDLE;
                            svalid_resp_o <= 1'b0;
                            sdata_o       <= 1'b0;
                            sready_o      <= 1'b1;
                        end else begin
                            tx_cnt  <= tx_cnt + TW'(1);
                            resp_sr <= {resp_sr[RESP_W-2:0], 1'b0};
                            sdata_o <= resp_sr[RESP_W-2];
                        end
                    end else begin
                        sclk_resp_o <= (phase != 2'd0);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: command frames in, bus requests and
// serial responses checked against hand-computed values.

module tb_serial_to_parallel;

    logic        clk_i    = 1'b0;
    logic        rst_i    = 1'b1;
    logic        sdata_i  = 1'b0;
    logic        sclk_i   = 1'b0;
    logic        svalid_i = 1'b0;
    logic        ready_i  = 1'b0;
    logic [7:0]  rdata_i  = 8'h00;
    logic        err_i    = 1'b0;
    logic        sready_o;
    logic        sdata_o;
    logic        sclk_resp_o;
    logic        svalid_resp_o;
    logic        valid_o;
    logic [13:0] addr_o;
    logic [7:0]  wdata_o;
    logic        we_o;

    int n_chk = 0;
    int n_err = 0;

    serial_to_parallel dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sdata_i       (sdata_i),
        .sclk_i        (sclk_i),
        .svalid_i      (svalid_i),
        .sready_o      (sready_o),
        .sdata_o       (sdata_o),
        .sclk_resp_o   (sclk_resp_o),
        .svalid_resp_o (svalid_resp_o),
        .valid_o       (valid_o),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .we_o          (we_o),
        .ready_i       (ready_i),
        .rdata_i       (rdata_i),
        .err_i         (err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] frame(input logic [1:0] cmd,
                                          input logic [13:0] a,
                                          input logic [7:0] d,
                                          input logic flip);
        return {1'b1, cmd, a, d, (^{cmd, a, d}) ^ flip, 1'b1};
    endfunction

    task automatic send_bits(input logic [26:0] f, input int n);
        svalid_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            sdata_i = f[26-i];
            #40 sclk_i = 1'b1;
            #40 sclk_i = 1'b0;
        end
        svalid_i = 1'b0;
        sdata_i  = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !valid_o; i++) @(negedge clk_i);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    endtask

    task automatic capture(output logic [11:0] f, output int nb,
                           output int hi);
        logic prev;
        f = '0; nb = 0; hi = 0; prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (svalid_resp_o) hi++;
            if (sclk_resp_o && !prev) begin
                f = {f[10:0], sdata_o};
                nb++;
            end
            prev = sclk_resp_o;
            if (!svalid_resp_o && hi > 0) break;
            @(negedge clk_i);
        end
    endtask

    task automatic txn(input string tag, input logic [26:0] fr,
                       input logic [13:0] ea, input logic [7:0] ed,
                       input logic ewe, input logic [7:0] rd,
                       input logic er, input logic [11:0] eresp);
        logic [11:0] f;
        int nb, hi;
        send_bits(fr, 27);
        wait_valid(tag);
        chk({tag, "_addr"}, {18'd0, addr_o}, {18'd0, ea});
        chk({tag, "_wdata"}, {24'd0, wdata_o}, {24'd0, ed});
        chk({tag, "_we"}, {31'd0, we_o}, {31'd0, ewe});
        chk({tag, "_busy"}, {31'd0, sready_o}, 32'd0);
        ready_i = 1'b1; rdata_i = rd; err_i = er;
        @(negedge clk_i);
        ready_i = 1'b0; rdata_i = 8'h00; err_i = 1'b0;
        chk({tag, "_vdrop"}, {31'd0, valid_o}, 32'd0);
        capture(f, nb, hi);
        chk({tag, "_resp"}, {20'd0, f}, {20'd0, eresp});
        chk({tag, "_nbits"}, nb, 32'd12);
        chk({tag, "_txlen"}, hi, 32'd48);
        chk({tag, "_rdy"}, {31'd0, sready_o}, 32'd1);
    endtask

    task automatic drop(input string tag, input logic [26:0] fr);
        logic sv, sr;
        sv = 1'b0; sr = 1'b0;
        send_bits(fr, 27);
        for (int i = 0; i < 300; i++) begin
            sv |= valid_o;
            sr |= svalid_resp_o;
            @(negedge clk_i);
        end
        chk({tag, "_novalid"}, {31'd0, sv}, 32'd0);
        chk({tag, "_noresp"}, {31'd0, sr}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, sready_o}, 32'd1);
    endtask

    initial begin
        logic [26:0] fr;
        repeat (4) @(negedge clk_i);
        chk("rst_outs", {22'd0, valid_o, we_o, sdata_o, sclk_resp_o,
            svalid_resp_o, sready_o, wdata_o}, 32'd0);
        chk("rst_addr", {18'd0, addr_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_release_rdy", {31'd0, sready_o}, 32'd1);

        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("stray_ready", {29'd0, valid_o, svalid_resp_o, sready_o},
            32'd1);

        txn("wr1000", frame(2'b01, 14'h1000, 8'h42, 1'b0),
            14'h1000, 8'h42, 1'b1, 8'h99, 1'b0, 12'h801);
        txn("wr2500", frame(2'b01, 14'h2500, 8'hAB, 1'b0),
            14'h2500, 8'hAB, 1'b1, 8'h00, 1'b0, 12'h801);
        txn("rd1800", frame(2'b00, 14'h1800, 8'h5A, 1'b0),
            14'h1800, 8'h00, 1'b0, 8'h55, 1'b0, 12'h955);

`ifdef S2P_PARITY_CHECK_EN
        drop("badpar", frame(2'b01, 14'h3000, 8'hFF, 1'b1));
`else
        txn("badpar", frame(2'b01, 14'h3000, 8'hFF, 1'b1),
            14'h3000, 8'hFF, 1'b1, 8'h00, 1'b0, 12'h801);
`endif

        drop("rsvd", frame(2'b11, 14'h1111, 8'h22, 1'b0));
        fr = frame(2'b01, 14'h0444, 8'h10, 1'b0);
        fr[0] = 1'b0;
        drop("nostop", fr);

        txn("split", frame(2'b10, 14'h0800, 8'h77, 1'b0),
            14'h0800, 8'h77, 1'b1, 8'hEE, 1'b1, 12'hC03);
        txn("rdmax", frame(2'b00, 14'h3FFF, 8'h00, 1'b0),
            14'h3FFF, 8'h00, 1'b0, 8'h3C, 1'b1, 12'hCF3);

        send_bits(frame(2'b01, 14'h2AAA, 8'h99, 1'b0), 10);
        repeat (10) @(negedge clk_i);
        chk("abort_novalid", {31'd0, valid_o}, 32'd0);
        chk("abort_rdy", {31'd0, sready_o}, 32'd1);
        txn("after_abort", frame(2'b01, 14'h0123, 8'h3C, 1'b0),
            14'h0123, 8'h3C, 1'b1, 8'h00, 1'b0, 12'h801);

        send_bits(frame(2'b01, 14'h0ABC, 8'hC3, 1'b0), 27);
        wait_valid("midreq");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midreq_outs", {22'd0, valid_o, we_o, sdata_o, sclk_resp_o,
            svalid_resp_o, sready_o, wdata_o}, 32'd0);
        chk("midreq_addr", {18'd0, addr_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midreq_rdy", {31'd0, sready_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
